// File: rtl/tspi_sd_responder.sv
// rtl/tspi_sd_responder.sv - SPI-mode SD card model: command decode, R1/R3/R7 responses, CMD17 reads
module tspi_sd_responder #(
  parameter logic [31:0] Ocr        = 32'h40FF_8000,
  parameter int          IdleCount  = 4,
  parameter int          MemLatency = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sck_i,
  input  logic        cs_ni,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        card_idle_o,
  output logic        crc_en_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_RX, S_GAP, S_RESP, S_RD_WAIT, S_TOKEN, S_DATA, S_CRC
  } state_t;

  localparam logic [7:0] IdleCnt  = IdleCount[7:0];
  localparam logic [7:0] AgeLimit = MemLatency[7:0];

  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [2:0]  sck_s;
  logic [1:0]  cs_s;
  logic [1:0]  mosi_s;
  logic        sck_rise, sck_fall, cs_off, mosi_bit;

  state_t      state;
  logic [47:0] cmd_sr;
  logic [5:0]  rx_cnt;
  logic        dec_pend;
  logic [39:0] resp_sr;
  logic [2:0]  resp_cnt;
  logic        rd_go;
  logic [6:0]  tx_sr;
  logic [2:0]  tx_cnt;
  logic        req_pend;
  logic [7:0]  req_age;
  logic [7:0]  buf_q;
  logic        buf_valid;
  logic [8:0]  byte_idx;
  logic [15:0] dat_crc;
  logic        crc_lo;
  logic [7:0]  acmd_cnt;
  logic        app_flag;

  // Sync chains; the edge detector looks at the second and third SCK flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_s  <= 3'b000;
      cs_s   <= 2'b11;
      mosi_s <= 2'b11;
    end else begin
      sck_s  <= {sck_s[1:0], sck_i};
      cs_s   <= {cs_s[0], cs_ni};
      mosi_s <= {mosi_s[0], mosi_i};
    end
  end

  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign cs_off   = cs_s[1];
  assign mosi_bit = mosi_s[1];

  logic [5:0]  dec_idx;
  logic [22:0] arg_lo;
  logic        crc_chk, crc_bad, illegal, resp_long, rd_ok;
  logic        nxt_idle, nxt_crc_en, nxt_app;
  logic [7:0]  nxt_cnt;
  logic [31:0] resp_word;
  logic [7:0]  r1;

  assign dec_idx = cmd_sr[45:40];
  assign arg_lo  = cmd_sr[30:8];

  always_comb begin
    nxt_idle   = card_idle_o;
    nxt_crc_en = crc_en_o;
    nxt_cnt    = acmd_cnt;
    nxt_app    = 1'b0;
    illegal    = 1'b0;
    resp_long  = 1'b0;
    resp_word  = 32'hFFFF_FFFF;
    rd_ok      = 1'b0;
    crc_chk    = (dec_idx == 6'd0) || (dec_idx == 6'd8) || crc_en_o;
    crc_bad    = (crc_chk && (crc7_calc(cmd_sr[47:8]) != cmd_sr[7:1])) || !cmd_sr[0];
    if (!crc_bad) begin
      case (dec_idx)
        6'd0: begin
          nxt_idle   = 1'b1;
          nxt_cnt    = 8'd0;
          nxt_crc_en = 1'b0;
        end
        6'd8: begin
          if (arg_lo[11:8] == 4'd1) begin
            resp_long = 1'b1;
            resp_word = {20'h00000, arg_lo[11:0]};
          end else begin
            illegal = 1'b1;
          end
        end
        6'd17: begin
          if (!card_idle_o) rd_ok = 1'b1;
          else illegal = 1'b1;
        end
        6'd41: begin
          if (app_flag) begin
            if (acmd_cnt < IdleCnt) nxt_cnt = acmd_cnt + 8'd1;
            if (nxt_cnt >= IdleCnt) nxt_idle = 1'b0;
          end else begin
            illegal = 1'b1;
          end
        end
        6'd55: nxt_app = 1'b1;
        6'd58: begin
          resp_long = 1'b1;
          resp_word = {~card_idle_o, Ocr[30:0]};
        end
        6'd59: nxt_crc_en = arg_lo[0];
        default: illegal = 1'b1;
      endcase
    end
    r1 = {4'b0000, crc_bad, illegal, 1'b0, nxt_idle};
  end

  logic       ld_en;
  logic [7:0] ld_byte;

  // Byte to start shifting at the next byte boundary, by state
  always_comb begin
    ld_en   = 1'b0;
    ld_byte = 8'hFF;
    case (state)
      S_GAP: ld_en = 1'b1;
      S_RESP: begin
        if (resp_cnt != 3'd0) begin
          ld_en   = 1'b1;
          ld_byte = resp_sr[39:32];
        end else if (rd_go) begin
          ld_en   = 1'b1;
          ld_byte = buf_valid ? 8'hFE : 8'hFF;
        end
      end
      S_RD_WAIT: begin
        ld_en   = 1'b1;
        ld_byte = buf_valid ? 8'hFE : 8'hFF;
      end
      S_TOKEN: begin
        ld_en   = 1'b1;
        ld_byte = buf_q;
      end
      S_DATA: begin
        ld_en   = 1'b1;
        ld_byte = (byte_idx == 9'd511) ? dat_crc[15:8] : buf_q;
      end
      S_CRC: begin
        ld_en   = !crc_lo;
        ld_byte = dat_crc[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cmd_sr      <= '0;
      rx_cnt      <= '0;
      dec_pend    <= 1'b0;
      resp_sr     <= '1;
      resp_cnt    <= '0;
      rd_go       <= 1'b0;
      tx_sr       <= '1;
      tx_cnt      <= '0;
      req_pend    <= 1'b0;
      req_age     <= '0;
      buf_q       <= '0;
      buf_valid   <= 1'b0;
      byte_idx    <= '0;
      dat_crc     <= '0;
      crc_lo      <= 1'b0;
      acmd_cnt    <= '0;
      app_flag    <= 1'b0;
      miso_o      <= 1'b1;
      miso_oe_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      card_idle_o <= 1'b1;
      crc_en_o    <= 1'b0;
    end else begin
      mem_req_o <= 1'b0;
      miso_oe_o <= ~cs_off;

      // A response later than MemLatency is dropped as stale
      if (req_pend) begin
        if (mem_rvalid_i) begin
          buf_q     <= mem_rdata_i;
          buf_valid <= 1'b1;
          req_pend  <= 1'b0;
        end else if (req_age == AgeLimit) begin
          req_pend <= 1'b0;
        end else begin
          req_age <= req_age + 8'd1;
        end
      end

      if (cs_off) begin
        state     <= S_IDLE;
        miso_o    <= 1'b1;
        tx_cnt    <= '0;
        dec_pend  <= 1'b0;
        rd_go     <= 1'b0;
        req_pend  <= 1'b0;
        buf_valid <= 1'b0;
      end else if (dec_pend) begin
        dec_pend    <= 1'b0;
        state       <= S_GAP;
        card_idle_o <= nxt_idle;
        crc_en_o    <= nxt_crc_en;
        acmd_cnt    <= nxt_cnt;
        app_flag    <= nxt_app;
        resp_sr     <= {r1, resp_word};
        resp_cnt    <= resp_long ? 3'd5 : 3'd1;
        rd_go       <= rd_ok;
        if (rd_ok) begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= {arg_lo, 9'b0};
          req_pend   <= 1'b1;
          req_age    <= '0;
          buf_valid  <= 1'b0;
          dat_crc    <= '0;
        end
      end else begin
        if (sck_rise) begin
          case (state)
            S_IDLE: begin
              if (!mosi_bit) begin
                state  <= S_CMD_RX;
                cmd_sr <= {cmd_sr[46:0], mosi_bit};
                rx_cnt <= 6'd1;
              end
            end
            S_CMD_RX: begin
              cmd_sr <= {cmd_sr[46:0], mosi_bit};
              rx_cnt <= rx_cnt + 6'd1;
              if (rx_cnt == 6'd47) dec_pend <= 1'b1;
            end
            default: ;
          endcase
        end

        if (sck_fall) begin
          if (tx_cnt != 3'd0) begin
            miso_o <= tx_sr[6];
            tx_sr  <= {tx_sr[5:0], 1'b1};
            tx_cnt <= tx_cnt - 3'd1;
          end else begin
            miso_o <= ld_en ? ld_byte[7] : 1'b1;
            tx_sr  <= ld_byte[6:0];
            tx_cnt <= ld_en ? 3'd7 : 3'd0;
            case (state)
              S_GAP: state <= S_RESP;
              S_RESP: begin
                if (resp_cnt != 3'd0) begin
                  resp_sr  <= {resp_sr[31:0], 8'hFF};
                  resp_cnt <= resp_cnt - 3'd1;
                end else if (rd_go) begin
                  state <= buf_valid ? S_TOKEN : S_RD_WAIT;
                end else begin
                  state <= S_IDLE;
                end
              end
              S_RD_WAIT: if (buf_valid) state <= S_TOKEN;
              S_TOKEN: begin
                state      <= S_DATA;
                byte_idx   <= '0;
                dat_crc    <= crc16_byte(dat_crc, buf_q);
                buf_valid  <= 1'b0;
                mem_req_o  <= 1'b1;
                mem_addr_o <= mem_addr_o + 32'd1;
                req_pend   <= 1'b1;
                req_age    <= '0;
              end
              S_DATA: begin
                if (byte_idx == 9'd511) begin
                  state  <= S_CRC;
                  crc_lo <= 1'b0;
                end else begin
                  byte_idx  <= byte_idx + 9'd1;
                  dat_crc   <= crc16_byte(dat_crc, buf_q);
                  buf_valid <= 1'b0;
                  if (byte_idx != 9'd510) begin
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= mem_addr_o + 32'd1;
                    req_pend   <= 1'b1;
                    req_age    <= '0;
                  end
                end
              end
              S_CRC: begin
                if (!crc_lo) begin
                  crc_lo <= 1'b1;
                end else begin
                  state <= S_IDLE;
                  rd_go <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tspi_sd_responder.sv
// tb/tb_tspi_sd_responder.sv - directed SPI-host bench for tspi_sd_responder
`timescale 1ns/1ps
module tb_tspi_sd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        card_idle;
  logic        crc_en;

  int n_vec = 0;
  int n_bad = 0;

  int          req_count = 0;
  int          seq_err = 0;
  int          addr_unstable = 0;
  logic [31:0] first_addr = '0;
  logic [31:0] last_addr = '0;

  tspi_sd_responder #(
    .Ocr(32'h40FF_8000),
    .IdleCount(2),
    .MemLatency(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sck_i(sck),
    .cs_ni(cs_n),
    .mosi_i(mosi),
    .miso_o(miso),
    .miso_oe_o(miso_oe),
    .mem_req_o(mem_req),
    .mem_addr_o(mem_addr),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata),
    .card_idle_o(card_idle),
    .crc_en_o(crc_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Mode 0 host: MOSI set and MISO sampled while SCK low, 8 clk per bit
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = miso;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [47:0] f;
    logic [7:0]  d;
    f = {2'b01, idx, arg, crc};
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], d);
  endtask

  task automatic expect_resp(input string tag, input int n, input logic [39:0] exp);
    logic [7:0]  b;
    logic [39:0] acc;
    xfer(8'hFF, b);
    chk({tag, "_ncr"}, 64'(b), 64'hFF);
    acc = '0;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, b);
      acc = {acc[31:0], b};
    end
    chk(tag, 64'(acc), 64'(exp));
  endtask

  task automatic wait_token(input string tag);
    logic [7:0] b;
    int         k;
    k = 0;
    b = 8'hFF;
    while (b != 8'hFE && k < 16) begin
      xfer(8'hFF, b);
      k++;
    end
    chk(tag, 64'(b), 64'hFE);
  endtask

  function automatic logic [15:0] crc16_model(input int n);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'h0000;
    for (int k = 0; k < n; k++) begin
      d = k[7:0];
      for (int b = 7; b >= 0; b--) begin
        if (c[15] ^ d[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
        else c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Byte-wide memory: data = addr[7:0], returned 3 cycles after the request
  initial begin
    logic [31:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        a = mem_addr;
        if (req_count > 0 && a != last_addr + 32'd1) seq_err++;
        if (req_count == 0) first_addr = a;
        last_addr = a;
        req_count++;
        repeat (3) @(negedge clk);
        if (mem_addr != a) addr_unstable++;
        mem_rvalid = 1'b1;
        mem_rdata  = a[7:0];
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach the end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] crc_hi, crc_lo;
    int         rc;

    rst  = 1'b1;
    sck  = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", 64'(miso), 64'd1);
    chk("rst_oe", 64'(miso_oe), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_idle", 64'(card_idle), 64'd1);
    chk("rst_crc_en", 64'(crc_en), 64'd0);

    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("cs_oe", 64'(miso_oe), 64'd1);

    send_cmd(6'd0, 32'h0, 8'h95);
    expect_resp("cmd0", 1, 40'h01);
    chk("cmd0_idle", 64'(card_idle), 64'd1);

    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    expect_resp("cmd8_r7", 5, 40'h01_0000_01AA);
    send_cmd(6'd8, 32'h0000_01AA, 8'h00);
    expect_resp("cmd8_badcrc", 1, 40'h09);

    rc = req_count;
    send_cmd(6'd17, 32'h1, 8'h01);
    expect_resp("cmd17_idle", 1, 40'h05);
    repeat (20) @(negedge clk);
    chk("cmd17_idle_noreq", 64'(req_count - rc), 64'd0);

    send_cmd(6'd5, 32'h0, 8'h01);
    expect_resp("cmd5_illegal", 1, 40'h05);
    send_cmd(6'd41, 32'h0, 8'h01);
    expect_resp("cmd41_noapp", 1, 40'h05);

    send_cmd(6'd55, 32'h0, 8'h01);
    expect_resp("cmd55_a", 1, 40'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'h01);
    expect_resp("acmd41_a", 1, 40'h01);
    send_cmd(6'd55, 32'h0, 8'h01);
    expect_resp("cmd55_b", 1, 40'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'h01);
    expect_resp("acmd41_b", 1, 40'h00);
    chk("init_idle", 64'(card_idle), 64'd0);

    send_cmd(6'd58, 32'h0, 8'h01);
    expect_resp("cmd58", 5, 40'h00_C0FF_8000);

    // Full single-block read at 0x200
    req_count = 0; seq_err = 0; addr_unstable = 0;
    send_cmd(6'd17, 32'h1, 8'h01);
    expect_resp("rd_r1", 1, 40'h00);
    wait_token("rd_token");
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, b);
      chk($sformatf("rd_data[%0d]", i), 64'(b), 64'(i[7:0]));
    end
    xfer(8'hFF, crc_hi);
    xfer(8'hFF, crc_lo);
    chk("rd_crc16", 64'({crc_hi, crc_lo}), 64'(crc16_model(512)));
    chk("rd_req_count", 64'(req_count), 64'd512);
    chk("rd_first_addr", 64'(first_addr), 64'h200);
    chk("rd_last_addr", 64'(last_addr), 64'h3FF);
    chk("rd_addr_seq", 64'(seq_err), 64'd0);
    chk("rd_addr_stable", 64'(addr_unstable), 64'd0);
    xfer(8'hFF, b);
    chk("rd_after_crc", 64'(b), 64'hFF);

    // Abort after data byte 100
    req_count = 0;
    send_cmd(6'd17, 32'h1, 8'h01);
    expect_resp("ab_r1", 1, 40'h00);
    wait_token("ab_token");
    for (int i = 0; i <= 100; i++) begin
      xfer(8'hFF, b);
      if (i == 0 || i == 100) chk($sformatf("ab_data[%0d]", i), 64'(b), 64'(i[7:0]));
    end
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ab_oe_off", 64'(miso_oe), 64'd0);
    chk("ab_miso_idle", 64'(miso), 64'd1);
    repeat (20) @(negedge clk);
    chk("ab_idle_kept", 64'(card_idle), 64'd0);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(6'd58, 32'h0, 8'h01);
    expect_resp("ab_cmd58", 5, 40'h00_C0FF_8000);

    // Short read at 0x400, then abort again
    req_count = 0;
    send_cmd(6'd17, 32'h2, 8'h01);
    expect_resp("rd2_r1", 1, 40'h00);
    wait_token("rd2_token");
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, b);
      chk($sformatf("rd2_data[%0d]", i), 64'(b), 64'(i[7:0]));
    end
    chk("rd2_first_addr", 64'(first_addr), 64'h400);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);

    // CRC checking on: a bad CRC is flagged without a state change, CMD0 clears it
    send_cmd(6'd59, 32'h1, 8'h01);
    expect_resp("cmd59", 1, 40'h00);
    chk("cmd59_crc_en", 64'(crc_en), 64'd1);
    send_cmd(6'd58, 32'h0, 8'h01);
    expect_resp("cmd58_badcrc", 1, 40'h08);
    chk("badcrc_idle", 64'(card_idle), 64'd0);
    send_cmd(6'd0, 32'h0, 8'h95);
    expect_resp("cmd0_again", 1, 40'h01);
    chk("cmd0_crc_en", 64'(crc_en), 64'd0);
    chk("cmd0_idle_again", 64'(card_idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
